sram_mem_ctrl: RTL and testbench

- Memory-stage controller between the EXE/MEM pipeline register and an external 16-bit asynchronous SRAM.
- Turns one 32-bit load or store into two halfword SRAM accesses, each held for a fixed number of wait cycles.
- Drives `ready` low while an access is in progress. The hazard/freeze logic uses it to stall the pipeline, keeping MEM-stage destination and write-back enable stable for the forwarding unit.

---
 rtl/sram_mem_ctrl.sv | 163 ++++++++++++++++
 tb/tb_sram_mem_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sram_mem_ctrl
// Desc     : MEM-stage controller splitting 32-bit loads/stores into two
//            halfword accesses on a 16-bit asynchronous SRAM.
//            Optional address range check: SRAM_MEM_CTRL_ADDR_CHECK_EN
// Revision : 1.0
// ============================================================================
module sram_mem_ctrl #(
  parameter int WAIT_CYCLES = 5,
  parameter int BASE_ADDR   = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  input  logic [15:0] sram_dq_in,
  output logic        sram_dq_oe,
  output logic        sram_we_n
`ifdef SRAM_MEM_CTRL_ADDR_CHECK_EN
  ,
  output logic        addr_err
`endif
);

  localparam int                 c_CNT_W = $clog2(WAIT_CYCLES + 1);
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WAIT_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);
  localparam logic [31:0]        c_BASE  = 32'(BASE_ADDR);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOW  = 2'd1,
    S_HIGH = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             r_state;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_is_wr;
  logic [16:0]        r_idx;
  logic [31:0]        r_wdata;
  logic [31:0]        r_rdata;
  logic [17:0]        r_addr;
  logic [15:0]        r_dq_out;
  logic               r_dq_oe;
  logic               r_we_n;

  logic [16:0]        w_idx;
  logic [c_CNT_W-1:0] w_cnt_inc;
  logic               w_last;
  logic               w_req;
  logic               w_addr_bad;

  assign w_req     = rd_en | wr_en;
  assign w_idx     = 17'((address - c_BASE) >> 2);
  assign w_cnt_inc = r_cnt + c_ONE;
  assign w_last    = (r_cnt == c_LAST);

`ifdef SRAM_MEM_CTRL_ADDR_CHECK_EN
  logic r_addr_err;

  assign w_addr_bad = (address < c_BASE) || (address[1:0] != 2'b00) ||
                      ((address - c_BASE) >= 32'h0008_0000);
  assign addr_err   = r_addr_err;
`else
  assign w_addr_bad = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_is_wr  <= 1'b0;
      r_idx    <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_addr   <= '0;
      r_dq_out <= '0;
      r_dq_oe  <= 1'b0;
      r_we_n   <= 1'b1;
`ifdef SRAM_MEM_CTRL_ADDR_CHECK_EN
      r_addr_err <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_is_wr <= wr_en;
            r_idx   <= w_idx;
            r_wdata <= write_data;
            if (w_addr_bad) begin
              r_state <= S_DONE;
`ifdef SRAM_MEM_CTRL_ADDR_CHECK_EN
              r_addr_err <= 1'b1;
`endif
            end else begin
              // Outputs are registered, so the low-half bus values are set up on entry
              r_state  <= S_LOW;
              r_cnt    <= '0;
              r_addr   <= {w_idx, 1'b0};
              r_dq_out <= write_data[15:0];
              r_dq_oe  <= wr_en;
              r_we_n   <= ~wr_en;
            end
          end
        end

        S_LOW: begin
          if (w_last) begin
            r_state  <= S_HIGH;
            r_cnt    <= '0;
            r_addr   <= {r_idx, 1'b1};
            r_dq_out <= r_wdata[31:16];
            r_we_n   <= ~r_is_wr;
            if (!r_is_wr) r_rdata[15:0] <= sram_dq_in;
          end else begin
            r_cnt  <= w_cnt_inc;
            r_we_n <= ~r_is_wr | (w_cnt_inc == c_LAST);
          end
        end

        S_HIGH: begin
          if (w_last) begin
            r_state <= S_DONE;
            r_cnt   <= '0;
            r_dq_oe <= 1'b0;
            r_we_n  <= 1'b1;
            if (!r_is_wr) r_rdata[31:16] <= sram_dq_in;
          end else begin
            r_cnt  <= w_cnt_inc;
            r_we_n <= ~r_is_wr | (w_cnt_inc == c_LAST);
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
`ifdef SRAM_MEM_CTRL_ADDR_CHECK_EN
          r_addr_err <= 1'b0;
`endif
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  // The stall must drop in the completing cycle so the pipeline advances there
  assign ready       = ~w_req | (r_state == S_DONE);
  assign read_data   = r_rdata;
  assign sram_addr   = r_addr;
  assign sram_dq_out = r_dq_out;
  assign sram_dq_oe  = r_dq_oe;
  assign sram_we_n   = r_we_n;

endmodule
`default_nettype wire

// File: tb/tb_sram_mem_ctrl.sv
`default_nettype none
// Self-checking bench for sram_mem_ctrl: transaction-level reference model
// compared every cycle, plus directed literal checks.
module tb_sram_mem_ctrl;

  localparam int W    = 5;
  localparam int BASE = 1024;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd_en, wr_en;
  logic [31:0] address, write_data;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic [15:0] sram_dq_in;
  logic        sram_dq_oe;
  logic        sram_we_n;
`ifdef SRAM_MEM_CTRL_ADDR_CHECK_EN
  logic        addr_err;
`endif

  sram_mem_ctrl #(.WAIT_CYCLES(W), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .wr_en(wr_en),
    .address(address), .write_data(write_data), .read_data(read_data),
    .ready(ready), .sram_addr(sram_addr), .sram_dq_out(sram_dq_out),
    .sram_dq_in(sram_dq_in), .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n)
`ifdef SRAM_MEM_CTRL_ADDR_CHECK_EN
    , .addr_err(addr_err)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Asynchronous SRAM: data written on the rising edge of the write strobe
  logic [15:0] sram [0:255];
  logic [15:0] mdl  [0:255];
  assign sram_dq_in = sram[sram_addr[7:0]];
  always @(posedge sram_we_n) if (sram_dq_oe === 1'b1) sram[sram_addr[7:0]] = sram_dq_out;

  // Reference model: position within the current transaction, 0 = idle
  int          pos    = 0;
  logic        m_wr   = 1'b0;
  logic        m_err  = 1'b0;
  logic [16:0] m_idx  = '0;
  logic [31:0] m_wd   = '0;
  logic [31:0] exp_rd = '0;
  logic        m_hi;
  int          m_j;

  always @(negedge clk) begin
    if (!rst_n) begin
      pos = 0; exp_rd = '0; m_err = 1'b0;
      chk("rst_we_n", 32'(sram_we_n), 32'd1);
      chk("rst_oe", 32'(sram_dq_oe), 32'd0);
      chk("rst_read_data", read_data, 32'd0);
    end else if (pos == 0) begin
      chk("idle_ready", 32'(ready), 32'(!(rd_en | wr_en)));
      chk("idle_oe", 32'(sram_dq_oe), 32'd0);
      chk("idle_we_n", 32'(sram_we_n), 32'd1);
      chk("idle_read_data", read_data, exp_rd);
`ifdef SRAM_MEM_CTRL_ADDR_CHECK_EN
      chk("idle_addr_err", 32'(addr_err), 32'd0);
`endif
      if (rd_en | wr_en) begin
        m_wr  = wr_en;
        m_idx = 17'((address - BASE) >> 2);
        m_wd  = write_data;
        pos   = 1;
`ifdef SRAM_MEM_CTRL_ADDR_CHECK_EN
        if (address < BASE || address[1:0] != 2'b00 || (address - BASE) >= 32'h80000) begin
          pos = 2 * W + 1; m_err = 1'b1;
        end
`endif
        if (pos == 1 && m_wr) begin
          mdl[{m_idx[6:0], 1'b0}] = m_wd[15:0];
          mdl[{m_idx[6:0], 1'b1}] = m_wd[31:16];
        end
      end
    end else if (pos <= 2 * W) begin
      m_hi = (pos > W);
      m_j  = (pos - 1) % W;
      chk("busy_ready", 32'(ready), 32'(!(rd_en | wr_en)));
      chk("sram_addr", 32'(sram_addr), 32'({m_idx, m_hi}));
      chk("busy_oe", 32'(sram_dq_oe), 32'(m_wr));
      chk("busy_we_n", 32'(sram_we_n), m_wr ? 32'(m_j == W - 1) : 32'd1);
      if (m_wr) chk("dq_out", 32'(sram_dq_out), m_hi ? 32'(m_wd[31:16]) : 32'(m_wd[15:0]));
      chk("busy_read_data", read_data, exp_rd);
`ifdef SRAM_MEM_CTRL_ADDR_CHECK_EN
      chk("busy_addr_err", 32'(addr_err), 32'd0);
`endif
      if (!m_wr && m_j == W - 1) begin
        if (m_hi) exp_rd[31:16] = mdl[{m_idx[6:0], 1'b1}];
        else      exp_rd[15:0]  = mdl[{m_idx[6:0], 1'b0}];
      end
      pos++;
    end else begin
      chk("done_ready", 32'(ready), 32'd1);
      chk("done_oe", 32'(sram_dq_oe), 32'd0);
      chk("done_we_n", 32'(sram_we_n), 32'd1);
      chk("done_read_data", read_data, exp_rd);
`ifdef SRAM_MEM_CTRL_ADDR_CHECK_EN
      chk("done_addr_err", 32'(addr_err), 32'(m_err));
`endif
      pos = 0; m_err = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Waits for ready with the request held; returns at the negedge where ready is high
  task automatic wait_done(input bit perturb, output int lows, output int we_lows, output bit oe_seen);
    bit done = 1'b0;
    lows = 0; we_lows = 0; oe_seen = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (sram_we_n === 1'b0) we_lows++;
      if (sram_dq_oe === 1'b1) oe_seen = 1'b1;
      if (ready === 1'b1) done = 1'b1;
      else begin
        lows++;
        if (perturb && c == 3) begin
          #1 address = $urandom; write_data = $urandom;
        end
      end
    end
    if (!done) begin
      n_checks++;
      $display("FAIL wait_done: ready still low after 40 cycles at %0t", $time);
    end
  endtask

  int          lows, we_lows;
  bit          oe_seen;
  logic [23:0] pat;
  bit          switched;

  initial begin
    rst_n = 1'b1; rd_en = 1'b0; wr_en = 1'b0; address = '0; write_data = '0;
    for (int i = 0; i < 256; i++) begin
      sram[i] = 16'($urandom);
      mdl[i]  = sram[i];
    end
    sram[0] = 16'hBEEF; mdl[0] = 16'hBEEF;
    sram[1] = 16'hDEAD; mdl[1] = 16'hDEAD;
    #1 rst_n = 1'b0;
    #2;
    chk("reset_read_data", read_data, 32'd0);
    chk("reset_sram_addr", 32'(sram_addr), 32'd0);
    chk("reset_dq_out", 32'(sram_dq_out), 32'd0);
    chk("reset_we_n", 32'(sram_we_n), 32'd1);
    chk("reset_ready", 32'(ready), 32'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // Read at BASE: 11 stall cycles, then DEADBEEF in the DONE cycle
    rd_en = 1'b1; address = 32'd1024;
    wait_done(1'b0, lows, we_lows, oe_seen);
    chk("read_lows", 32'(lows), 32'd11);
    chk("read_data_lit", read_data, 32'hDEADBEEF);
    chk("read_we_lows", 32'(we_lows), 32'd0);
    tick(); rd_en = 1'b0;
    tick();

    // Write at 1032 -> halfwords 4 and 5, strobe low 4 of 5 cycles per phase
    wr_en = 1'b1; address = 32'd1032; write_data = 32'h12345678;
    wait_done(1'b0, lows, we_lows, oe_seen);
    chk("write_lows", 32'(lows), 32'd11);
    chk("write_we_lows", 32'(we_lows), 32'd8);
    tick(); wr_en = 1'b0;
    chk("write_sram4", 32'(sram[4]), 32'h5678);
    chk("write_sram5", 32'(sram[5]), 32'h1234);
    chk("write_keeps_rd", read_data, 32'hDEADBEEF);
    tick();

    // Simultaneous request: write wins
    rd_en = 1'b1; wr_en = 1'b1; address = 32'd1040; write_data = 32'hCAFEF00D;
    wait_done(1'b0, lows, we_lows, oe_seen);
    chk("both_oe_seen", 32'(oe_seen), 32'd1);
    tick(); rd_en = 1'b0; wr_en = 1'b0;
    chk("both_sram8", 32'(sram[8]), 32'hF00D);
    chk("both_sram9", 32'(sram[9]), 32'hCAFE);
    chk("both_keeps_rd", read_data, 32'hDEADBEEF);
    tick();

    // Back-to-back reads held continuously
    rd_en = 1'b1; address = 32'd1024; pat = '0; switched = 1'b0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      pat = {pat[22:0], ready};
      if (ready && !switched) begin
        switched = 1'b1;
        @(posedge clk); #1 address = 32'd1028;
      end
    end
    chk("b2b_ready_pattern", 32'(pat), 32'h001001);
    tick(); rd_en = 1'b0;
    tick();

    // Asynchronous reset during the low phase of a write
    wr_en = 1'b1; address = 32'd1064; write_data = {sram[21], sram[20]};
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_we_n", 32'(sram_we_n), 32'd1);
    chk("midrst_oe", 32'(sram_dq_oe), 32'd0);
    chk("midrst_addr", 32'(sram_addr), 32'd0);
    chk("midrst_ready", 32'(ready), 32'd0);
    wr_en = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // Randomized traffic: back-to-back, gaps, mid-access drops and input changes
    for (int t = 0; t < 40; t++) begin
      repeat ($urandom_range(0, 2)) tick();
      address    = 32'(BASE) + 32'($urandom_range(0, 127)) * 32'd4;
      write_data = $urandom;
      case ($urandom_range(0, 2))
        0:       begin rd_en = 1'b1; wr_en = 1'b0; end
        1:       begin rd_en = 1'b0; wr_en = 1'b1; end
        default: begin rd_en = 1'b1; wr_en = 1'b1; end
      endcase
      if ($urandom_range(0, 4) == 0) begin
        repeat ($urandom_range(1, 8)) tick();
        rd_en = 1'b0; wr_en = 1'b0; address = $urandom; write_data = $urandom;
        repeat (2 * W + 2) tick();
      end else begin
        wait_done(1'b1, lows, we_lows, oe_seen);
        tick(); rd_en = 1'b0; wr_en = 1'b0;
      end
    end
    tick();

`ifdef SRAM_MEM_CTRL_ADDR_CHECK_EN
    rd_en = 1'b1; address = 32'd1026;
    @(negedge clk);
    chk("err_first_ready", 32'(ready), 32'd0);
    @(negedge clk);
    chk("err_done_ready", 32'(ready), 32'd1);
    chk("err_flag", 32'(addr_err), 32'd1);
    chk("err_we_n", 32'(sram_we_n), 32'd1);
    tick(); rd_en = 1'b0;
    @(negedge clk);
    chk("err_flag_clear", 32'(addr_err), 32'd0);
    tick();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
